// File: rtl/nco_i2s_tx_pkg.sv
// Shared constants for the NCO-to-I2S transmit path: default slot width,
// frame length helper and word-select polarity. Pure definitions, no logic,
// so no latency or flow-control behaviour of its own.
package nco_i2s_tx_pkg;

  // Default I2S slot width in bits per channel.
  localparam int DEF_SLW = 16;

  // Word-select polarity: left channel while low, right channel while high.
  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

  // Bits in one stereo frame (left slot followed by right slot).
  function automatic int frame_bits(input int slw);
    return 2 * slw;
  endfunction

endpackage

// File: rtl/nco_smp_fifo.sv
// Small synchronous sample FIFO between the NCO and the I2S serialiser.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: none; the caller only pushes when not full (or while popping) and pops when not empty.
module nco_smp_fifo #(
  parameter int W  = 14,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_vld,
  output logic [W-1:0]  pop_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   lvl
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;

  // Next-state for storage, pointers and occupancy; push and pop may coincide.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push_vld) begin
      mem_d[wp_q] = push_dat;
      wp_d        = wp_q + 1'b1;
    end
    if (pop_vld) begin
      rp_d = rp_q + 1'b1;
    end
    case ({push_vld, pop_vld})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with asynchronous clear so a reset empties the FIFO at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign pop_dat = mem_q[rp_q];
  assign full    = (cnt_q == LVL_FULL);
  assign empty   = (cnt_q == '0);
  assign lvl     = cnt_q;

endmodule

// File: rtl/nco_i2s_tx.sv
// I2S master transmitter fed by the NCO sample stream; same sample on both channels.
// Latency: a sample into an empty FIFO reaches DACDAT MSB at k=1 of the next frame's left slot.
// Backpressure: none upstream; FIFO full drops the push (sticky ovf), empty at frame start repeats (sticky udf).
module nco_i2s_tx
  import nco_i2s_tx_pkg::*;
#(
  parameter int mpr  = 14,
  parameter int slw  = DEF_SLW,
  parameter int bdiv = 4,
  parameter int fdl2 = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [mpr-1:0]  smp_i,
  input  logic            smp_valid_i,
  input  logic            tx_en,
  input  logic            flag_clr,
  output logic            aud_bclk,
  output logic            aud_daclrck,
  output logic            aud_dacdat,
  output logic [fdl2:0]   fifo_lvl,
  output logic            ovf,
  output logic            udf
);

  localparam int FB = frame_bits(slw);
  localparam int BW = $clog2(FB);
  localparam int DW = $clog2(bdiv);
  localparam logic [DW-1:0] DIV_LAST = DW'(bdiv - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(FB - 1);
  localparam logic [BW-1:0] B_HALF   = BW'(slw);

  // Registered state.
  logic [DW-1:0]  div_q, div_d;
  logic           bclk_q, bclk_d;
  logic [BW-1:0]  b_q, b_d;
  logic           lrck_q, lrck_d;
  logic           dat_q, dat_d;
  logic [slw-1:0] w_q, w_d;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;

  // Combinational event decode.
  logic           div_wrap;
  logic           shift_ev;
  logic [BW-1:0]  b_nxt;
  logic           frame_start;
  logic           right_half;
  logic [BW-1:0]  k;
  logic [BW-1:0]  bit_idx;
  logic [slw-1:0] w_shr;
  logic [slw-1:0] w_load;
  logic           fifo_pop;
  logic           fifo_push;
  logic           ovf_ev;
  logic           udf_ev;

  // FIFO interface.
  logic [mpr-1:0] fifo_dat;
  logic           fifo_full;
  logic           fifo_empty;

  nco_smp_fifo #(
    .W  (mpr),
    .AW (fdl2)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset_n),
    .push_vld (fifo_push),
    .push_dat (smp_i),
    .pop_vld  (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .lvl      (fifo_lvl)
  );

  // Decode BCLK falling edge, frame position and FIFO push/pop decisions.
  always_comb begin
    div_wrap    = (div_q == DIV_LAST);
    // BCLK is about to fall: this clk is the shift event.
    shift_ev    = div_wrap && bclk_q;
    b_nxt       = (b_q == B_LAST) ? '0 : b_q + 1'b1;
    frame_start = shift_ev && (b_nxt == '0);
    right_half  = (b_nxt >= B_HALF);
    k           = right_half ? (b_nxt - B_HALF) : b_nxt;
    // Slot bit k (k>=1) carries w[slw-k]; shift it down to bit 0.
    bit_idx     = B_HALF - k;
    w_shr       = w_q >> bit_idx;
    // Left-align the sample in the slot word, zero-padding the LSBs.
    w_load      = slw'(fifo_dat) << (slw - mpr);
    // Pop looks at the occupancy before this clk, so an empty FIFO never pops
    // even if a push lands in the same cycle.
    fifo_pop    = frame_start && tx_en && !fifo_empty;
    udf_ev      = frame_start && tx_en && fifo_empty;
    // A full FIFO that is popping this cycle still has room for the push.
    fifo_push   = smp_valid_i && (!fifo_full || fifo_pop);
    ovf_ev      = smp_valid_i && fifo_full && !fifo_pop;
  end

  // Next-state for divider, bit counter, slot word, serial outputs and flags.
  always_comb begin
    div_d  = div_wrap ? '0 : div_q + 1'b1;
    bclk_d = div_wrap ? ~bclk_q : bclk_q;
    b_d    = b_q;
    lrck_d = lrck_q;
    dat_d  = dat_q;
    w_d    = w_q;

    if (shift_ev) begin
      b_d    = b_nxt;
      lrck_d = right_half ? LRCK_RIGHT : LRCK_LEFT;
      // k=0 is the delayed LSB of the previous channel word; at a frame start
      // that is the old word, so it must be taken before w is reloaded.
      dat_d  = (k == '0) ? w_q[0] : w_shr[0];
    end

    if (frame_start) begin
      if (!tx_en) begin
        w_d = '0;
      end else if (!fifo_empty) begin
        w_d = w_load;
      end else begin
        w_d = w_q;
      end
    end

    // A new event outranks a clear in the same cycle.
    ovf_d = ovf_ev ? 1'b1 : (flag_clr ? 1'b0 : ovf_q);
    udf_d = udf_ev ? 1'b1 : (flag_clr ? 1'b0 : udf_q);
  end

  // State registers; reset parks the bit counter on the last right-slot bit so
  // the first shift event after reset starts a fresh frame on the left channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      b_q    <= B_LAST;
      lrck_q <= LRCK_RIGHT;
      dat_q  <= 1'b0;
      w_q    <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
      b_q    <= b_d;
      lrck_q <= lrck_d;
      dat_q  <= dat_d;
      w_q    <= w_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign aud_bclk    = bclk_q;
  assign aud_daclrck = lrck_q;
  assign aud_dacdat  = dat_q;
  assign ovf         = ovf_q;
  assign udf         = udf_q;

endmodule
